// File: rtl/qerv_fetch_pkg.sv
// Shared types and constants for the qerv instruction-fetch aligner.
package qerv_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WADR_W = 30;

  // Low two bits of a halfword that starts a 32-bit (uncompressed) instruction.
  localparam logic [1:0] FULL_OP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_HIT,
    S_COOL
  } fetch_state_e;

  function automatic logic is_full(input logic [HALF_W-1:0] h);
    return h[1:0] == FULL_OP;
  endfunction

endpackage

// File: rtl/qerv_fetch_aligner.sv
// Turns halfword-aligned core fetches into word reads, stitching straddling
// 32-bit instructions and serving buffered compressed ones without a bus cycle.
module qerv_fetch_aligner
  import qerv_fetch_pkg::*;
#(
  parameter int unsigned WITH_C = 1
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_ibus_adr,
  input  logic            i_ibus_cyc,
  output logic [XLEN-1:0] o_ibus_rdt,
  output logic            o_ibus_ack,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_wb_ibus_adr,
  output logic            o_wb_ibus_cyc,
  input  logic [XLEN-1:0] i_wb_ibus_rdt,
  input  logic            i_wb_ibus_ack
);

  localparam bit USE_C = (WITH_C != 0);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:1]   adr_q, adr_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic [HALF_W-1:0] hbuf_q, hbuf_d;
  logic [WADR_W-1:0] htag_q, htag_d;
  logic              hvld_q, hvld_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   rdt_q, rdt_d;
  logic              ack_q, ack_d;
  logic [XLEN-1:0]   wb_adr_q, wb_adr_d;
  logic              wb_cyc_q, wb_cyc_d;

  logic              req_half_c;
  logic              hit_c;
  logic              abort_c;
  logic [WADR_W-1:0] nxt_word_c;
  logic              unused_c;

  assign unused_c = i_ibus_adr[0];

  // Next-state and next-output logic; every register gets its hold value first.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    lo_d     = lo_q;
    hbuf_d   = hbuf_q;
    htag_d   = htag_q;
    hvld_d   = hvld_q;
    drop_d   = drop_q;
    rdt_d    = rdt_q;
    ack_d    = 1'b0;
    wb_adr_d = wb_adr_q;
    wb_cyc_d = wb_cyc_q;

    req_half_c = USE_C && i_ibus_adr[1];
    hit_c      = USE_C && hvld_q && !i_flush && (htag_q == i_ibus_adr[31:2]);
    abort_c    = drop_q || !i_ibus_cyc;
    nxt_word_c = WADR_W'(adr_q[31:2] + WADR_W'(1));

    case (state_q)
      S_IDLE: begin
        if (i_ibus_cyc) begin
          adr_d  = {i_ibus_adr[31:2], req_half_c};
          drop_d = 1'b0;
          if (req_half_c && hit_c && !is_full(hbuf_q)) begin
            state_d = S_HIT;
          end else if (req_half_c && hit_c) begin
            state_d  = S_HI;
            lo_d     = hbuf_q;
            wb_cyc_d = 1'b1;
            wb_adr_d = {WADR_W'(i_ibus_adr[31:2] + WADR_W'(1)), 2'b00};
          end else begin
            state_d  = S_LO;
            wb_cyc_d = 1'b1;
            wb_adr_d = {i_ibus_adr[31:2], 2'b00};
          end
        end
      end

      S_LO: begin
        if (!i_ibus_cyc) drop_d = 1'b1;
        if (i_wb_ibus_ack) begin
          if (USE_C) begin
            hbuf_d = i_wb_ibus_rdt[31:16];
            htag_d = adr_q[31:2];
            hvld_d = 1'b1;
          end
          if (abort_c) begin
            state_d  = S_IDLE;
            wb_cyc_d = 1'b0;
          end else if (!adr_q[1]) begin
            ack_d    = 1'b1;
            rdt_d    = i_wb_ibus_rdt;
            state_d  = S_COOL;
            wb_cyc_d = 1'b0;
          end else if (!is_full(i_wb_ibus_rdt[31:16])) begin
            ack_d    = 1'b1;
            rdt_d    = {16'h0000, i_wb_ibus_rdt[31:16]};
            state_d  = S_COOL;
            wb_cyc_d = 1'b0;
          end else begin
            // Straddle: keep the bus cycle open and move on to the next word.
            lo_d     = i_wb_ibus_rdt[31:16];
            wb_adr_d = {nxt_word_c, 2'b00};
            state_d  = S_HI;
          end
        end
      end

      S_HI: begin
        if (!i_ibus_cyc) drop_d = 1'b1;
        if (i_wb_ibus_ack) begin
          hbuf_d   = i_wb_ibus_rdt[31:16];
          htag_d   = nxt_word_c;
          hvld_d   = 1'b1;
          wb_cyc_d = 1'b0;
          if (abort_c) begin
            state_d = S_IDLE;
          end else begin
            ack_d   = 1'b1;
            rdt_d   = {i_wb_ibus_rdt[15:0], lo_q};
            state_d = S_COOL;
          end
        end
      end

      S_HIT: begin
        ack_d   = 1'b1;
        rdt_d   = {16'h0000, hbuf_q};
        state_d = S_COOL;
      end

      S_COOL: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (i_flush) hvld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      lo_q     <= '0;
      hbuf_q   <= '0;
      htag_q   <= '0;
      hvld_q   <= 1'b0;
      drop_q   <= 1'b0;
      rdt_q    <= '0;
      ack_q    <= 1'b0;
      wb_adr_q <= '0;
      wb_cyc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      lo_q     <= lo_d;
      hbuf_q   <= hbuf_d;
      htag_q   <= htag_d;
      hvld_q   <= hvld_d;
      drop_q   <= drop_d;
      rdt_q    <= rdt_d;
      ack_q    <= ack_d;
      wb_adr_q <= wb_adr_d;
      wb_cyc_q <= wb_cyc_d;
    end
  end

  assign o_ibus_rdt    = rdt_q;
  assign o_ibus_ack    = ack_q;
  assign o_wb_ibus_adr = wb_adr_q;
  assign o_wb_ibus_cyc = wb_cyc_q;

endmodule

// File: tb/tb_qerv_fetch_aligner.sv
// Bench for qerv_fetch_aligner: directed cases plus randomized fetch streams
// checked against an instruction-level model of fetch results and bus traffic.
module tb_qerv_fetch_aligner;

  logic        clk;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        i_flush;
  logic [31:0] o_wb_ibus_adr;
  logic        o_wb_ibus_cyc;
  logic [31:0] i_wb_ibus_rdt;
  logic        i_wb_ibus_ack;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] bus_log [$];
  int          mem_lat = 1;
  int          mem_cnt = 0;

  // Model of buffer contents: only which word is buffered; data comes from mem.
  bit          m_vld = 1'b0;
  logic [29:0] m_tag = '0;

  qerv_fetch_aligner #(.WITH_C(1)) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_ibus_adr    (i_ibus_adr),
    .i_ibus_cyc    (i_ibus_cyc),
    .o_ibus_rdt    (o_ibus_rdt),
    .o_ibus_ack    (o_ibus_ack),
    .i_flush       (i_flush),
    .o_wb_ibus_adr (o_wb_ibus_adr),
    .o_wb_ibus_cyc (o_wb_ibus_cyc),
    .i_wb_ibus_rdt (i_wb_ibus_rdt),
    .i_wb_ibus_ack (i_wb_ibus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  // Memory: acks mem_lat cycles after cyc is seen, one-cycle ack pulse.
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i_wb_ibus_ack <= 1'b0;
      i_wb_ibus_rdt <= '0;
      mem_cnt       <= 0;
    end else if (i_wb_ibus_ack) begin
      i_wb_ibus_ack <= 1'b0;
    end else if (o_wb_ibus_cyc) begin
      if (mem_cnt + 1 >= mem_lat) begin
        i_wb_ibus_ack <= 1'b1;
        i_wb_ibus_rdt <= mem_rd(o_wb_ibus_adr[31:2]);
        mem_cnt       <= 0;
        bus_log.push_back(o_wb_ibus_adr);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    m_vld = 1'b0;
  endtask

  // One core fetch; expectations follow from instruction length and buffer contents.
  task automatic do_fetch(input logic [31:0] pc, input int lat, input bit fl,
                          output logic [31:0] rdt_obs);
    logic [29:0] w;
    logic [31:0] wd, wd1, exp_rdt;
    logic [15:0] first;
    logic        full, hit;
    logic [29:0] reads [$];
    int          exp_lat, lat_obs, base;

    w     = pc[31:2];
    wd    = mem_rd(w);
    wd1   = mem_rd(30'(w + 30'd1));
    first = pc[1] ? wd[31:16] : wd[15:0];
    full  = (first[1:0] == 2'b11);
    hit   = m_vld && !fl && (m_tag == w);
    if (!pc[1]) begin
      reads.push_back(w);
      exp_rdt = wd;
      exp_lat = lat + 2;
    end else if (full) begin
      if (!hit) reads.push_back(w);
      reads.push_back(30'(w + 30'd1));
      exp_rdt = {wd1[15:0], first};
      exp_lat = hit ? lat + 2 : 2 * lat + 3;
    end else begin
      if (!hit) reads.push_back(w);
      exp_rdt = {16'h0000, first};
      exp_lat = hit ? 2 : lat + 2;
    end

    base       = bus_log.size();
    mem_lat    = lat;
    i_ibus_adr = pc;
    i_ibus_cyc = 1'b1;
    i_flush    = fl;
    lat_obs    = 0;
    rdt_obs    = 'x;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (o_ibus_ack) begin
        lat_obs = k;
        rdt_obs = o_ibus_rdt;
        break;
      end
    end
    i_ibus_cyc = 1'b0;
    i_flush    = 1'b0;

    check("latency", 32'(lat_obs), 32'(exp_lat));
    check("rdt", rdt_obs, exp_rdt);
    @(posedge clk); #1;
    check("ack_pulse", 32'(o_ibus_ack), 32'd0);
    check("bus_reads", 32'(bus_log.size() - base), 32'(reads.size()));
    for (int i = 0; i < reads.size() && base + i < bus_log.size(); i++)
      check("bus_adr", bus_log[base + i], {reads[i], 2'b00});

    if (reads.size() > 0) begin
      m_vld = 1'b1;
      m_tag = reads[reads.size() - 1];
    end
    if (fl) m_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, pc;
    int          base, nack;
    bit          seen;

    i_rst_n    = 1'b0;
    i_ibus_adr = '0;
    i_ibus_cyc = 1'b0;
    i_flush    = 1'b0;
    #2;
    check("rst_ack", 32'(o_ibus_ack), 32'd0);
    check("rst_rdt", o_ibus_rdt, 32'd0);
    check("rst_wb_cyc", 32'(o_wb_ibus_cyc), 32'd0);
    check("rst_wb_adr", o_wb_ibus_adr, 32'd0);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word, L=1.
    mem[30'h40] = 32'h00A0_0093;
    do_fetch(32'h0000_0100, 1, 1'b0, r);
    check("tp_aligned_rdt", r, 32'h00A0_0093);

    // Compressed upper halfword served from the buffer.
    mem[30'h40] = 32'h4501_4501;
    do_fetch(32'h0000_0100, 1, 1'b0, r);
    base = bus_log.size();
    do_fetch(32'h0000_0102, 2, 1'b0, r);
    check("tp_hit_rdt", r, 32'h0000_4501);
    check("tp_hit_nobus", 32'(bus_log.size() - base), 32'd0);

    // Miss straddle, then the buffer tag must point at the second word.
    mem[30'h81] = 32'h0093_1234;
    mem[30'h82] = 32'h5678_00A0;
    do_fetch(32'h0000_0206, 2, 1'b0, r);
    check("tp_straddle_rdt", r, 32'h00A0_0093);
    do_fetch(32'h0000_020A, 1, 1'b0, r);
    check("tp_htag_rdt", r, 32'h0000_5678);

    // Straddle across the top of the address space.
    mem[30'h3FFF_FFFF] = 32'h0093_1111;
    mem[30'h0]         = 32'hBEEF_00A0;
    do_fetch(32'hFFFF_FFFC, 1, 1'b0, r);
    do_fetch(32'hFFFF_FFFE, 2, 1'b0, r);
    check("tp_wrap_rdt", r, 32'h00A0_0093);
    check("tp_wrap_adr", bus_log[bus_log.size() - 1], 32'h0000_0000);

    // Flush alone, then flush together with a request.
    mem[30'h40] = 32'h4501_4501;
    do_fetch(32'h0000_0100, 1, 1'b0, r);
    pulse_flush();
    do_fetch(32'h0000_0102, 1, 1'b0, r);
    check("tp_flush_adr", bus_log[bus_log.size() - 1], 32'h0000_0100);
    do_fetch(32'h0000_0102, 1, 1'b1, r);

    // Reset while the second word of a straddle is on the bus.
    pulse_flush();
    mem_lat    = 5;
    base       = bus_log.size();
    i_ibus_adr = 32'h0000_0206;
    i_ibus_cyc = 1'b1;
    seen       = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus_log.size() == base + 1 && o_wb_ibus_cyc) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_reach_hi", 32'(seen), 32'd1);
    #3 i_rst_n = 1'b0;
    #1;
    check("midrst_wb_cyc", 32'(o_wb_ibus_cyc), 32'd0);
    check("midrst_ack", 32'(o_ibus_ack), 32'd0);
    check("midrst_wb_adr", o_wb_ibus_adr, 32'd0);
    i_ibus_cyc = 1'b0;
    m_vld      = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    do_fetch(32'h0000_0206, 1, 1'b0, r);
    check("postrst_rdt", r, 32'h00A0_0093);

    // Core redirect while the bus read is outstanding.
    pulse_flush();
    mem[30'hC0] = 32'h4501_1234;
    mem_lat     = 3;
    base        = bus_log.size();
    i_ibus_adr  = 32'h0000_0300;
    i_ibus_cyc  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_ibus_cyc = 1'b0;
    nack       = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_ibus_ack) nack++;
    end
    check("redir_no_ack", 32'(nack), 32'd0);
    check("redir_wb_cyc", 32'(o_wb_ibus_cyc), 32'd0);
    check("redir_reads", 32'(bus_log.size() - base), 32'd1);
    m_vld = 1'b1;
    m_tag = 30'hC0;
    do_fetch(32'h0000_0302, 2, 1'b0, r);
    check("redir_hit_rdt", r, 32'h0000_4501);

    // Randomized fetch streams, mostly sequential, some jumps and flushes.
    for (int i = 0; i < 16; i++) begin
      mem[30'(i)]                 = $urandom;
      mem[30'h3FFF_FFF0 + 30'(i)] = $urandom;
    end
    pulse_flush();
    pc = 32'h0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        pc = pc + 32'd2;
      end else begin
        pc = {($urandom_range(0, 1) != 0) ? 30'($urandom_range(0, 15))
                                          : 30'h3FFF_FFF0 + 30'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'b0};
      end
      pc[0] = 1'($urandom_range(0, 1));
      do_fetch(pc, int'($urandom_range(1, 3)), ($urandom_range(0, 9) == 0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
